// File: rtl/fifo_stream_reader.sv
// Read-side front end for a synchronous FIFO: hides the one-cycle read latency behind a 3-entry buffer.
// Read_EN to m_valid takes 2 cycles; reads pause once buffered plus in-flight words reach 3, never on m_ready.
module fifo_stream_reader #(
   parameter int DATA_WIDTH  = 16,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   Empty,
   input  logic [DATA_WIDTH-1:0]  DataOut,
   output logic                   Read_EN,
   input  logic                   flush,
   output logic                   m_valid,
   output logic [DATA_WIDTH-1:0]  m_data,
   input  logic                   m_ready,
   output logic [COUNT_WIDTH-1:0] rd_count
);
   logic [DATA_WIDTH-1:0] buffer [3];
   logic [1:0]            occ;
   logic [1:0]            head;
   logic [1:0]            tail;
   logic                  inflight;
   logic [2:0]            pending;
   logic                  capture;
   logic                  xfer;

   // Counting the in-flight word guarantees a free slot for every read already issued.
   assign pending = {1'b0, occ} + {2'b00, inflight};
   assign Read_EN = !rst && !flush && !Empty && (pending < 3'd3);
   assign m_valid = (occ != 2'd0);
   assign m_data  = buffer[head];
   assign capture = inflight && !flush;
   assign xfer    = m_valid && m_ready;

   function automatic logic [1:0] next_ptr(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         occ      <= '0;
         head     <= '0;
         tail     <= '0;
         inflight <= 1'b0;
         rd_count <= '0;
         for (int i = 0; i < 3; i++) buffer[i] <= '0;
      end else begin
         // A word handed over during a flush cycle still counts as delivered.
         if (xfer) rd_count <= rd_count + COUNT_WIDTH'(1);
         if (flush) begin
            occ      <= '0;
            head     <= '0;
            tail     <= '0;
            inflight <= 1'b0;
         end else begin
            inflight <= Read_EN;
            if (capture) begin
               buffer[tail] <= DataOut;
               tail         <= next_ptr(tail);
            end
            if (xfer) head <= next_ptr(head);
            case ({capture, xfer})
               2'b10:   occ <= occ + 2'd1;
               2'b01:   occ <= occ - 2'd1;
               default: occ <= occ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO model upstream, cycle table plus directed sequences.
module tb_fifo_stream_reader;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        m_ready = 1'b0;
   logic        Empty;
   logic [15:0] DataOut = '0;
   logic        Read_EN;
   logic        m_valid;
   logic [15:0] m_data;
   logic [15:0] rd_count;
   logic        re4;
   logic        mv4;
   logic [15:0] md4;
   logic [3:0]  rc4;

   always #5 clk = ~clk;

   fifo_stream_reader #(.DATA_WIDTH(16), .COUNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .Empty(Empty), .DataOut(DataOut), .Read_EN(Read_EN),
      .flush(flush), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .rd_count(rd_count));

   fifo_stream_reader #(.DATA_WIDTH(16), .COUNT_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .Empty(Empty), .DataOut(DataOut), .Read_EN(re4),
      .flush(flush), .m_valid(mv4), .m_data(md4), .m_ready(m_ready), .rd_count(rc4));

   // Upstream FIFO model: one-cycle read latency, contents untouched by DUT reset/flush.
   logic [15:0] fmem [0:255];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign Empty = (rd_ptr == wr_ptr);
   always @(posedge clk) begin
      if (Read_EN) begin
         DataOut <= fmem[rd_ptr];
         rd_ptr  <= rd_ptr + 1;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Passive logging of reads and transfers plus invariant tracking.
   int          re_n = 0;
   int          re_cyc [0:1023];
   int          rx_n = 0;
   logic [15:0] rx_dat [0:1023];
   int          rx_cyc [0:1023];
   int          inv_viol = 0;
   int          hold_viol = 0;
   int          mirror_viol = 0;
   int          uflow_viol = 0;
   logic        hold_prev = 1'b0;
   logic [15:0] hold_dat = '0;
   always @(negedge clk) begin
      if (Read_EN) begin
         re_cyc[re_n] = cyc;
         re_n++;
         if (Empty) uflow_viol++;
      end
      if (!rst && m_valid && m_ready) begin
         rx_dat[rx_n] = m_data;
         rx_cyc[rx_n] = cyc;
         rx_n++;
      end
      if (!rst && (int'(dut.occ) + int'(dut.inflight)) > 3) inv_viol++;
      if (hold_prev && !(m_valid && m_data == hold_dat)) hold_viol++;
      hold_prev = !rst && !flush && m_valid && !m_ready;
      hold_dat  = m_data;
      if (re4 !== Read_EN || mv4 !== m_valid || (mv4 && md4 !== m_data)) mirror_viol++;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] v);
      fmem[wr_ptr] = v;
      wr_ptr++;
   endtask

   task automatic reset_dut();
      rst   = 1'b1;
      flush = 1'b0;
      tick();
      tick();
   endtask

   task automatic stream_run(input int n, input bit toggle, input int budget);
      int k;
      int base;
      k    = 0;
      base = rx_n;
      while ((rx_n - base) < n && k < budget) begin
         m_ready = toggle ? ~k[0] : 1'b1;
         @(negedge clk);
         tick();
         k++;
      end
      chk("stream_word_count", rx_n - base, n);
   endtask

   typedef struct packed {
      logic        rdy;
      logic        re;
      logic        mv;
      logic        dchk;
      logic [15:0] dat;
   } vec_t;

   vec_t tbl [13];
   int   rxb;
   int   reb;
   int   c0;

   initial begin
      // Cold start with 5 words queued: 3 reads under backpressure, then drain.
      tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd0};
      tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd1};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'd1};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'd1};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'd1};
      tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'd1};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd2};
      tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd3};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'd4};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'd5};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
      tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0};

      reset_dut();
      for (int i = 1; i <= 5; i++) push(16'(i));
      tick();
      @(negedge clk);
      chk("reset_read_en", Read_EN, 1'b0);
      chk("reset_m_valid", m_valid, 1'b0);
      chk("reset_m_data", m_data, 16'd0);
      chk("reset_rd_count", rd_count, 16'd0);
      tick();
      rst = 1'b0;
      reb = re_n;
      for (int i = 0; i < 13; i++) begin
         m_ready = tbl[i].rdy;
         @(negedge clk);
         chk($sformatf("tbl%0d_read_en", i), Read_EN, tbl[i].re);
         chk($sformatf("tbl%0d_m_valid", i), m_valid, tbl[i].mv);
         if (tbl[i].dchk) chk($sformatf("tbl%0d_m_data", i), m_data, tbl[i].dat);
         tick();
      end
      chk("bp_read_pulses", re_n - reb, 5);
      chk("bp_rd_count", rd_count, 16'd5);

      // Full-throughput stream of 32 words.
      reset_dut();
      for (int i = 1; i <= 32; i++) push(16'(i));
      reb = re_n;
      rxb = rx_n;
      m_ready = 1'b1;
      rst = 1'b0;
      stream_run(32, 1'b0, 100);
      repeat (3) tick();
      @(negedge clk);
      chk("tp_read_pulses", re_n - reb, 32);
      c0 = re_cyc[reb];
      chk("tp_read_span", re_cyc[reb + 31] - c0, 31);
      for (int i = 0; i < 32; i++) begin
         chk($sformatf("tp_word%0d", i), rx_dat[rxb + i], 16'(i + 1));
         chk($sformatf("tp_cycle%0d", i), rx_cyc[rxb + i] - c0, i + 2);
      end
      chk("tp_rd_count", rd_count, 16'd32);
      chk("tp_m_valid_after", m_valid, 1'b0);
      chk("tp_rd_count4_wrap", rc4, 4'd0);
      tick();

      // m_ready toggling over 20 words.
      reset_dut();
      for (int i = 0; i < 20; i++) push(16'(101 + i));
      rxb = rx_n;
      rst = 1'b0;
      stream_run(20, 1'b1, 200);
      m_ready = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      for (int i = 0; i < 20; i++) chk($sformatf("tg_word%0d", i), rx_dat[rxb + i], 16'(101 + i));
      chk("tg_rd_count", rd_count, 16'd20);
      chk("tg_rd_count4", rc4, 4'd4);
      tick();

      // Flush with three buffered words while the consumer is ready.
      reset_dut();
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(16'(301 + i));
      rxb = rx_n;
      rst = 1'b0;
      repeat (6) tick();
      flush = 1'b1;
      m_ready = 1'b1;
      @(negedge clk);
      chk("fl_read_en_in_flush", Read_EN, 1'b0);
      chk("fl_m_data_in_flush", m_data, 16'd301);
      tick();
      flush = 1'b0;
      @(negedge clk);
      chk("fl_m_valid_after", m_valid, 1'b0);
      chk("fl_rd_count_after", rd_count, 16'd1);
      chk("fl_read_en_resume", Read_EN, 1'b1);
      tick();
      stream_run(5, 1'b0, 50);
      repeat (3) tick();
      @(negedge clk);
      chk("fl_word0", rx_dat[rxb], 16'd301);
      for (int i = 1; i < 6; i++) chk($sformatf("fl_word%0d", i), rx_dat[rxb + i], 16'(303 + i));
      chk("fl_rd_count_end", rd_count, 16'd6);
      tick();

      // Reset mid-stream: 401..406 read, 401..404 delivered, 405/406 dropped.
      reset_dut();
      for (int i = 0; i < 20; i++) push(16'(401 + i));
      rxb = rx_n;
      m_ready = 1'b1;
      rst = 1'b0;
      repeat (6) tick();
      rst = 1'b1;
      @(negedge clk);
      chk("rs_read_en_rst1", Read_EN, 1'b0);
      chk("rs_rd_count_before", rd_count, 16'd4);
      tick();
      @(negedge clk);
      chk("rs_read_en_rst2", Read_EN, 1'b0);
      chk("rs_m_valid_rst2", m_valid, 1'b0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rs_m_valid_after", m_valid, 1'b0);
      chk("rs_rd_count_after", rd_count, 16'd0);
      chk("rs_delivered_before", rx_n - rxb, 4);
      tick();
      stream_run(14, 1'b0, 60);
      repeat (3) tick();
      @(negedge clk);
      for (int i = 0; i < 14; i++) chk($sformatf("rs_word%0d", i), rx_dat[rxb + 4 + i], 16'(407 + i));
      chk("rs_rd_count_end", rd_count, 16'd14);
      tick();

      // 4-bit counter wraps after 18 transfers.
      reset_dut();
      for (int i = 0; i < 18; i++) push(16'(501 + i));
      m_ready = 1'b1;
      rst = 1'b0;
      stream_run(18, 1'b0, 60);
      repeat (3) tick();
      @(negedge clk);
      chk("wr_rd_count4", rc4, 4'd2);
      chk("wr_rd_count16", rd_count, 16'd18);

      chk("occupancy_invariant_violations", inv_viol, 0);
      chk("hold_stability_violations", hold_viol, 0);
      chk("fifo_underflow_reads", uflow_viol, 0);
      chk("narrow_instance_divergence", mirror_viol, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
